aud_trace_fifo: RTL and testbench
=================================

Name: aud_trace_fifo

Overview:
Dual-clock trace buffer directly downstream of the AUD branch-trace receiver. Captures each branch event (address plus validity and error flags) in the aud_ck domain and delivers it to the system-clock domain through a gray-pointer asynchronous FIFO with a valid/ready read port. Sits between the AUD receiver and the host-side trace packetizer.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO entries (16 entries by default).
ADDR_W, 32, branch address width.
TS_W, 16, timestamp width; used only when AUD_TS_EN is defined.

Ports:
rst  in  1  reset, asynchronous, active-high; applies to both domains.
aud_ck  in  1  AUD trace clock; the write side uses the rising edge (the producer updates on the falling edge).
sys_clk  in  1  read-side clock.
br_addr  in  ADDR_W  branch address from the receiver.
oe  in  1  one-cycle branch strobe from the receiver.
addr_valid  in  1  1 = complete address, 0 = truncated (last-good substituted).
buserror  in  1  receiver bus-error level.
wr_full  out  1  FIFO full (aud_ck domain).
rd_data  out  ENTRY_W  entry: {ovf, err, addr_valid, addr[ADDR_W-1:0]}, plus ts[TS_W-1:0] in the LSBs when AUD_TS_EN is defined.
rd_valid  out  1  rd_data holds the head entry (show-ahead).
rd_ready  in  1  consumer accepts the head entry.
rd_level  out  DEPTH_LOG2+1  occupied entries, as seen from the sys_clk domain.

Behaviour:
- Reset: both pointers, synchronizers and flags clear. wr_full=0, rd_valid=0, rd_data=0, rd_level=0. Per-domain reset-deassertion synchronizers (2 flops) are required; assertion is immediate.
- Write event (aud_ck rising edge): occurs when oe=1, or on the rising edge of buserror (previous sample 0, current sample 1).
  - oe=1: entry = {ovf_pend, buserror, addr_valid, br_addr}.
  - buserror rising edge only: entry = {ovf_pend, 1, 0, 0}.
  - oe=1 and buserror rising edge in the same cycle: write one entry only, the oe entry with err=1.
- Full: an event while wr_full=1 is dropped and sets the sticky ovf_pend. The next accepted write carries ovf=1 and clears ovf_pend.
- Pointers: DEPTH_LOG2+1 bits, binary internally, gray-coded across domains through 2-flop synchronizers.
  - full = wr_gray equals rd_gray_sync with its top two bits inverted.
  - empty = rd_gray equals wr_gray_sync.
  - Pointers wrap modulo 2^(DEPTH_LOG2+1).
- Read: rd_valid=!empty. Transfer occurs on a sys_clk edge when rd_valid and rd_ready are both 1; the read pointer then advances.
  - rd_data is stable while rd_valid=1 and rd_ready=0.
  - rd_ready while rd_valid=0 has no effect.
- Latency: a written entry becomes visible (rd_valid=1) 2–3 sys_clk cycles after the write edge. A freed slot clears wr_full 2–3 aud_ck cycles after the read.
- rd_level = wr_ptr_sync − rd_ptr, computed modulo 2^(DEPTH_LOG2+1). It is registered, one sys_clk cycle behind.
- Storage: a register array, written in the aud_ck domain and read combinationally at rd_ptr. No read-during-write hazard, because full/empty blocks same-slot access.
- Reset mid-operation: all content is discarded; no partial entry is ever presented. ovf_pend clears.
- aud_ck stopping: entries already written still drain on the sys_clk side.

Optional Feature:
AUD_TS_EN:
- Defined: a TS_W-bit free-running counter in the aud_ck domain, incremented every aud_ck cycle, reset to 0 and wrapping. Each entry stores the counter value at the write edge in ts. ENTRY_W = ADDR_W+3+TS_W.
- Undefined: no counter, no ts field. ENTRY_W = ADDR_W+3.

Decomposition:
- Package aud_pkg holds:
  - entry field bit positions (OVF_BIT, ERR_BIT, VALID_BIT, ADDR_LSB);
  - the ENTRY_W calculation;
  - bin2gray/gray2bin functions.
- Sub-module aud_gray_sync: a parameterized-width 2-flop synchronizer with async reset, instantiated twice (once per pointer direction).

Test Plan:
1. aud_ck 20 MHz, sys_clk 50 MHz, rd_ready=1. One oe pulse, br_addr=0x0800_1234, addr_valid=1 -> one entry {ovf=0, err=0, valid=1, 0x08001234} within 3 sys_clk cycles; rd_level returns to 0.
2. rd_ready=0, 20 oe pulses with addresses 1..20 -> wr_full=1 after 16 writes; events 17–20 dropped. Then rd_ready=1, one more oe with addr 21 -> 16 entries drain in order 1..16, then addr 21 with ovf=1.
3. buserror 0->1 with no oe -> entry {0,1,0,0x0}. buserror held at 1 for 10 cycles -> no further entries.
4. oe=1, addr_valid=0, br_addr=0xAAAA_5555 in the same cycle as the buserror rising edge -> exactly one entry {0,1,0,0xAAAA5555}.
5. Write 5 entries, assert rst mid-drain for 2 cycles -> rd_valid=0, rd_level=0, wr_full=0 immediately. Post-reset writes are read correctly.
6. AUD_TS_EN defined: oe pulses at aud_ck cycles 10 and 17 after reset release -> ts difference between the two entries = 7.

Source files
------------

// File: rtl/aud_pkg.sv
// Entry layout and gray-code helpers shared by the AUD trace FIFO.
// Defining AUD_TS_EN adds a timestamp field in the entry LSBs.
package aud_pkg;

`ifdef AUD_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  // Entry = {ovf, err, addr_valid, addr, [ts]}, fields counted up from the LSB.
  function automatic int unsigned addr_lsb(input int unsigned ts_w);
    return TS_EN ? ts_w : 0;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned addr_w, input int unsigned ts_w);
    return addr_lsb(ts_w) + addr_w;
  endfunction

  function automatic int unsigned err_bit(input int unsigned addr_w, input int unsigned ts_w);
    return valid_bit(addr_w, ts_w) + 1;
  endfunction

  function automatic int unsigned ovf_bit(input int unsigned addr_w, input int unsigned ts_w);
    return valid_bit(addr_w, ts_w) + 2;
  endfunction

  function automatic int unsigned entry_w(input int unsigned addr_w, input int unsigned ts_w);
    return valid_bit(addr_w, ts_w) + 3;
  endfunction

  // Width-agnostic: callers zero-extend into 32 bits and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/aud_gray_sync.sv
// Two-flop synchronizer for a gray-coded pointer crossing into the clk domain.
module aud_gray_sync #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/aud_trace_fifo.sv
// AUD branch-trace capture FIFO: aud_ck write side, sys_clk show-ahead read side.
// Optional AUD_TS_EN macro adds a free-running aud_ck timestamp to each entry.
module aud_trace_fifo
  import aud_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned TS_W       = 16,
  localparam int unsigned ENTRY_W   = entry_w(ADDR_W, TS_W)
) (
  input  logic                  rst,
  input  logic                  aud_ck,
  input  logic                  sys_clk,
  input  logic [ADDR_W-1:0]     br_addr,
  input  logic                  oe,
  input  logic                  addr_valid,
  input  logic                  buserror,
  output logic                  wr_full,
  output logic [ENTRY_W-1:0]    rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   rd_level
);

  localparam int unsigned PW        = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned OVF_BIT   = ovf_bit(ADDR_W, TS_W);
  localparam int unsigned ERR_BIT   = err_bit(ADDR_W, TS_W);
  localparam int unsigned VALID_BIT = valid_bit(ADDR_W, TS_W);
  localparam int unsigned ADDR_LSB  = addr_lsb(TS_W);
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  // Reset asserts immediately in both domains, releases after two local edges.
  logic [1:0] wr_rst_q;
  logic [1:0] rd_rst_q;
  logic       wr_rst;
  logic       rd_rst;

  always_ff @(posedge aud_ck or posedge rst) begin
    if (rst) wr_rst_q <= '1;
    else     wr_rst_q <= {wr_rst_q[0], 1'b0};
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) rd_rst_q <= '1;
    else     rd_rst_q <= {rd_rst_q[0], 1'b0};
  end

  assign wr_rst = wr_rst_q[1];
  assign rd_rst = rd_rst_q[1];

  // ---------------- aud_ck write domain ----------------
  logic               bus_q;
  logic               ovf_pend_q, ovf_pend_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      wr_gray_q, wr_gray_d;
  logic [PW-1:0]      rd_gray_sync;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] wr_entry;
  logic               bus_rise, wr_event, wr_en;
`ifdef AUD_TS_EN
  logic [TS_W-1:0]    ts_q, ts_d;
`endif

  assign wr_full = (wr_gray_q == (rd_gray_sync ^ FULL_MASK));

  always_comb begin
    bus_rise = buserror & ~bus_q;
    wr_event = oe | bus_rise;
    wr_en    = wr_event & ~wr_full;

    // A bus-error edge coinciding with oe folds into the oe entry as err=1.
    wr_entry            = '0;
    wr_entry[OVF_BIT]   = ovf_pend_q;
    wr_entry[ERR_BIT]   = oe ? buserror : 1'b1;
    wr_entry[VALID_BIT] = oe & addr_valid;
    if (oe) wr_entry[ADDR_LSB +: ADDR_W] = br_addr;
`ifdef AUD_TS_EN
    wr_entry[TS_W-1:0] = ts_q;
    ts_d = ts_q + TS_W'(1);
`endif

    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    wr_gray_d  = PW'(bin2gray(32'(wr_ptr_d)));
    ovf_pend_d = wr_en ? 1'b0 : (wr_event | ovf_pend_q);
  end

  always_ff @(posedge aud_ck or posedge wr_rst) begin
    if (wr_rst) begin
      bus_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      wr_gray_q  <= '0;
`ifdef AUD_TS_EN
      ts_q       <= '0;
`endif
    end else begin
      bus_q      <= buserror;
      ovf_pend_q <= ovf_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_gray_q  <= wr_gray_d;
`ifdef AUD_TS_EN
      ts_q       <= ts_d;
`endif
    end
  end

  always_ff @(posedge aud_ck) begin
    if (wr_en) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_entry;
  end

  // ---------------- sys_clk read domain ----------------
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] rd_level_q, rd_level_d;
  logic [PW-1:0] wr_gray_sync, wr_ptr_sync;
  logic          rd_empty, rd_xfer;

  always_comb begin
    wr_ptr_sync = PW'(gray2bin(32'(wr_gray_sync)));
    rd_empty    = (rd_gray_q == wr_gray_sync);
    rd_xfer     = ~rd_empty & rd_ready;
    rd_ptr_d    = rd_ptr_q + PW'(rd_xfer);
    rd_gray_d   = PW'(bin2gray(32'(rd_ptr_d)));
    rd_level_d  = wr_ptr_sync - rd_ptr_q;
  end

  always_ff @(posedge sys_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_q   <= '0;
      rd_gray_q  <= '0;
      rd_level_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      rd_gray_q  <= rd_gray_d;
      rd_level_q <= rd_level_d;
    end
  end

  // Gating on empty keeps stale slots invisible, including during reset.
  assign rd_valid = ~rd_empty;
  assign rd_data  = rd_empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign rd_level = rd_level_q;

  aud_gray_sync #(.W(PW)) u_wr2rd_sync (
    .clk (sys_clk),
    .rst (rd_rst),
    .d   (wr_gray_q),
    .q   (wr_gray_sync)
  );

  aud_gray_sync #(.W(PW)) u_rd2wr_sync (
    .clk (aud_ck),
    .rst (wr_rst),
    .d   (rd_gray_q),
    .q   (rd_gray_sync)
  );

endmodule

// File: tb/tb_aud_trace_fifo.sv
// Self-checking bench for aud_trace_fifo: queue-based reference model of the
// event/overflow rules, with a sys_clk consumer collecting delivered entries.
`timescale 1ns/1ps
module tb_aud_trace_fifo;

  localparam int unsigned DL = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned TW = 16;
  localparam int          DEPTH = 16;
`ifdef AUD_TS_EN
  localparam int unsigned TSF = TW;
`else
  localparam int unsigned TSF = 0;
`endif
  localparam int unsigned EW = AW + 3 + TSF;
  localparam int unsigned KW = AW + 3;

  logic          rst, aud_ck, sys_clk;
  logic [AW-1:0] br_addr;
  logic          oe, addr_valid, buserror;
  logic          wr_full, rd_valid, rd_ready;
  logic [EW-1:0] rd_data;
  logic [DL:0]   rd_level;

  aud_trace_fifo #(.DEPTH_LOG2(DL), .ADDR_W(AW), .TS_W(TW)) dut (
    .rst        (rst),
    .aud_ck     (aud_ck),
    .sys_clk    (sys_clk),
    .br_addr    (br_addr),
    .oe         (oe),
    .addr_valid (addr_valid),
    .buserror   (buserror),
    .wr_full    (wr_full),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_level   (rd_level)
  );

  // 20 MHz aud_ck, 50 MHz sys_clk offset so no edges coincide.
  initial begin aud_ck = 1'b0; forever #25 aud_ck = ~aud_ck; end
  initial begin sys_clk = 1'b0; #3; forever #10 sys_clk = ~sys_clk; end

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;          // 0: hold low, 1: hold high, 2: random
  int n_acc = 0;               // entries the model says were accepted
  int n_got = 0;               // entries the consumer has taken
  int stab_err = 0;
  longint last_got_t = 0;
  logic [KW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  bit m_prev_be = 1'b0;
  bit m_ovf = 1'b0;

  // Consumer: choose rd_ready for the coming edge, then record the transfer.
  initial begin
    logic [EW-1:0] hold_data;
    bit holding;
    holding = 1'b0;
    hold_data = '0;
    rd_ready = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (ready_mode == 2) rd_ready = 1'($urandom_range(0, 1));
      else                 rd_ready = (ready_mode == 1);
      if (holding && rd_valid && (rd_data !== hold_data)) stab_err++;
      holding = 1'b0;
      if (rd_valid && rd_ready) begin
        got_q.push_back(rd_data);
        n_got++;
        last_got_t = longint'($time);
      end else if (rd_valid) begin
        holding = 1'b1;
        hold_data = rd_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // One aud_ck cycle of producer stimulus plus the model's view of it.
  task automatic aud_step(input bit s_oe, input logic [AW-1:0] s_addr, input bit s_av, input bit s_be);
    bit ev;
    @(negedge aud_ck);
    oe = s_oe; br_addr = s_addr; addr_valid = s_av; buserror = s_be;
    ev = s_oe || (s_be && !m_prev_be);
    m_prev_be = s_be;
    if (ev) begin
      if (n_acc - n_got >= DEPTH) m_ovf = 1'b1;
      else begin
        exp_q.push_back(s_oe ? {m_ovf, s_be, s_av, s_addr} : {m_ovf, 1'b1, 1'b0, {AW{1'b0}}});
        m_ovf = 1'b0;
        n_acc++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) aud_step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk); #1;
      if (n_got >= n_acc) begin ok = 1'b1; break; end
    end
    repeat (10) @(negedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge aud_ck);
    rst = 1'b1; oe = 1'b0; buserror = 1'b0; addr_valid = 1'b0; br_addr = '0;
    repeat (2) @(negedge aud_ck);
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    n_acc = 0; n_got = 0; m_ovf = 1'b0; m_prev_be = 1'b0;
    idle(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; oe = 1'b0; buserror = 1'b0; addr_valid = 1'b0; br_addr = '0;
    repeat (3) @(negedge aud_ck);
    #1;
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got %b exp 0", wr_full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    checks++; if (rd_level !== '0) begin errors++; $display("FAIL reset_rd_level got %0d exp 0", rd_level); end
    rst = 1'b0;
    idle(4);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rd_valid got %b exp 0", rd_valid); end
  endtask

  task automatic test_single();
    bit ok;
    longint t_wr;
    int lat;
    logic [EW-1:0] g;
    logic [KW-1:0] e;
    ready_mode = 1;
    repeat (2) @(negedge sys_clk);
    aud_step(1'b1, 32'h0800_1234, 1'b1, 1'b0);
    t_wr = longint'($time) + 25;
    idle(1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain got %0d entries exp %0d", n_got, n_acc); end
    lat = 0;
    for (longint t = 13; t <= last_got_t - 10; t += 20) if (t > t_wr) lat++;
    checks++; if (lat < 2 || lat > 3) begin errors++; $display("FAIL single_latency got %0d cycles exp 2..3", lat); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g[EW-1:TSF] !== e) begin errors++; $display("FAIL single_entry got %h exp %h", g[EW-1:TSF], e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (rd_level !== '0) begin errors++; $display("FAIL single_level got %0d exp 0", rd_level); end
  endtask

  task automatic test_full_ovf();
    bit ok;
    logic [EW-1:0] g;
    logic [KW-1:0] e;
    ready_mode = 0;
    repeat (3) @(negedge sys_clk);
    for (int i = 1; i <= 20; i++) begin
      aud_step(1'b1, AW'(i), 1'b1, 1'b0);
      if (i == 16 || i == 17) begin
        checks++;
        if (wr_full !== (i == 17)) begin errors++; $display("FAIL full_edge after %0d writes got %b exp %b", i - 1, wr_full, i == 17); end
      end
    end
    idle(2);
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_hold got %b exp 1", wr_full); end
    checks++; if (rd_level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", rd_level); end
    ready_mode = 1;
    for (int i = 0; i < 100 && n_got < 1; i++) @(negedge sys_clk);
    idle(4);
    aud_step(1'b1, AW'(21), 1'b1, 1'b0);
    idle(1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_drain got %0d entries exp %0d", n_got, n_acc); end
    checks++;
    if (got_q.size() != 17 || exp_q.size() != 17) begin errors++; $display("FAIL full_count got %0d exp 17 (model %0d)", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g[EW-1:TSF] !== e) begin errors++; $display("FAIL full_entry got %h exp %h", g[EW-1:TSF], e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (stab_err != 0) begin errors++; $display("FAIL full_hold_stable got %0d changes exp 0", stab_err); end
  endtask

  task automatic test_buserror();
    bit ok;
    logic [EW-1:0] g;
    logic [KW-1:0] e;
    ready_mode = 1;
    for (int i = 0; i < 11; i++) aud_step(1'b0, '0, 1'b0, 1'b1);
    aud_step(1'b0, '0, 1'b0, 1'b0);
    idle(1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL buserr_drain got %0d entries exp %0d", n_got, n_acc); end
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL buserr_count got %0d exp 1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g[EW-1:TSF] !== e) begin errors++; $display("FAIL buserr_entry got %h exp %h", g[EW-1:TSF], e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_same_cycle();
    bit ok;
    logic [EW-1:0] g;
    logic [KW-1:0] e;
    ready_mode = 1;
    aud_step(1'b1, 32'hAAAA_5555, 1'b0, 1'b1);
    aud_step(1'b0, '0, 1'b0, 1'b0);
    idle(1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL same_drain got %0d entries exp %0d", n_got, n_acc); end
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL same_count got %0d exp 1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g[EW-1:TSF] !== e) begin errors++; $display("FAIL same_entry got %h exp %h", g[EW-1:TSF], e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit ok, s_oe, s_be;
    int start;
    logic [EW-1:0] g;
    logic [KW-1:0] e;
    ready_mode = 2;
    start = n_acc;
    s_be = 1'b0;
    for (int i = 0; i < 60; i++) begin
      s_oe = ($urandom_range(0, 3) == 0);
      s_be = s_be ^ ($urandom_range(0, 7) == 0);
      if (n_acc - start >= 12) begin s_oe = 1'b0; s_be = 1'b0; end
      aud_step(s_oe, $urandom, 1'($urandom_range(0, 1)), s_be);
    end
    idle(2);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain got %0d entries exp %0d", n_got, n_acc); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g[EW-1:TSF] !== e) begin errors++; $display("FAIL rand_entry got %h exp %h", g[EW-1:TSF], e); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (stab_err != 0) begin errors++; $display("FAIL rand_stable got %0d changes exp 0", stab_err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [EW-1:0] g;
    logic [KW-1:0] e;
    ready_mode = 0;
    for (int i = 0; i < 5; i++) aud_step(1'b1, $urandom, 1'b1, 1'b0);
    idle(1);
    ready_mode = 1;
    repeat (3) @(negedge sys_clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_level !== '0) begin errors++; $display("FAIL midrst_rd_level got %0d exp 0", rd_level); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL midrst_wr_full got %b exp 0", wr_full); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL midrst_rd_data got %h exp 0", rd_data); end
    repeat (2) @(negedge aud_ck);
    rst = 1'b0;
    exp_q.delete(); got_q.delete();
    n_acc = 0; n_got = 0; m_ovf = 1'b0; m_prev_be = 1'b0;
    idle(4);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_empty got %b exp 0", rd_valid); end
    for (int i = 0; i < 3; i++) aud_step(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    idle(1);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_drain got %0d entries exp %0d", n_got, n_acc); end
    checks++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin errors++; $display("FAIL midrst_count got %0d exp 3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g[EW-1:TSF] !== e) begin errors++; $display("FAIL midrst_entry got %h exp %h", g[EW-1:TSF], e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef AUD_TS_EN
  task automatic test_ts();
    bit ok;
    logic [EW-1:0] g0, g1;
    logic [KW-1:0] e0, e1;
    logic [TW-1:0] diff;
    do_reset();
    ready_mode = 1;
    aud_step(1'b1, 32'h1111_0000, 1'b1, 1'b0);
    idle(6);
    aud_step(1'b1, 32'h2222_0000, 1'b1, 1'b0);
    idle(1);
    wait_drain(ok);
    checks++;
    if (!ok || got_q.size() != 2 || exp_q.size() != 2) begin
      errors++; $display("FAIL ts_count got %0d exp 2", got_q.size());
    end else begin
      g0 = got_q.pop_front(); g1 = got_q.pop_front();
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      diff = g1[TW-1:0] - g0[TW-1:0];
      checks++; if (diff !== TW'(7)) begin errors++; $display("FAIL ts_delta got %0d exp 7", diff); end
      checks++; if (g0[EW-1:TSF] !== e0) begin errors++; $display("FAIL ts_entry0 got %h exp %h", g0[EW-1:TSF], e0); end
      checks++; if (g1[EW-1:TSF] !== e1) begin errors++; $display("FAIL ts_entry1 got %h exp %h", g1[EW-1:TSF], e1); end
    end
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_full_ovf();
    test_buserror();
    test_same_cycle();
    test_random();
    test_reset_mid();
`ifdef AUD_TS_EN
    test_ts();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
